// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake game blocks.
// S_SCAN exists only when FOOD_SCAN_EN is defined.
package snake_pkg;

  localparam int COORD_W    = 8;
  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SET_X,
    S_SAMP_X,
    S_SET_Y,
    S_SAMP_Y,
    S_QUERY,
    S_DONE,
    S_FAIL
`ifdef FOOD_SCAN_EN
    ,
    S_SCAN
`endif
  } food_state_t;

endpackage

// File: rtl/food_spawner_if.sv
// Occupancy lookup handshake between the food spawner and the body logic.
// master = spawner (asks), slave = body-occupancy lookup (answers).
interface food_spawner_if;
  import snake_pkg::*;

  logic   occ_req;
  coord_t occ_x;
  coord_t occ_y;
  logic   occ_ack;
  logic   occ_hit;

  modport master (
    output occ_req, occ_x, occ_y,
    input  occ_ack, occ_hit
  );

  modport slave (
    input  occ_req, occ_x, occ_y,
    output occ_ack, occ_hit
  );

endinterface

// File: rtl/food_spawner.sv
// Places food on a free grid cell using the shared random counter.
// Define FOOD_SCAN_EN to fall back to a linear scan when retries run out.
module food_spawner
  import snake_pkg::*;
#(
  parameter int GRID_W    = GRID_W_DEF,
  parameter int GRID_H    = GRID_H_DEF,
  parameter int MAX_TRIES = 16
) (
  input  logic   clock,
  input  logic   resetn,
  input  logic   spawn_req,
  input  coord_t rand_num,
  output coord_t rand_max,
  food_spawner_if.master occ,
  output coord_t food_x,
  output coord_t food_y,
  output logic   food_valid,
  output logic   spawn_done,
  output logic   spawn_fail,
  output logic   busy
);

  localparam coord_t X_LIM   = coord_t'(GRID_W - 1);
  localparam coord_t Y_LIM   = coord_t'(GRID_H - 1);
  localparam coord_t TRY_LIM = coord_t'(MAX_TRIES);

  food_state_t state;
  food_state_t state_nxt;

  coord_t cand_x;
  coord_t cand_y;
  coord_t tries;
  coord_t tries_inc;
  logic   x_ok;
  logic   y_ok;
  logic   exhausted;

  assign x_ok      = (rand_num <= X_LIM);
  assign y_ok      = (rand_num <= Y_LIM);
  assign tries_inc = tries + 8'd1;
  assign exhausted = (tries_inc == TRY_LIM);

`ifdef FOOD_SCAN_EN
  localparam logic [15:0] CELLS = 16'(GRID_W * GRID_H);

  logic [15:0] scan_cnt;
  logic        scan_last;
  logic        x_wrap;
  coord_t      step_x;
  coord_t      step_y;

  assign scan_last = ((scan_cnt + 16'd1) == CELLS);
  assign x_wrap    = (cand_x == X_LIM);
  assign step_x    = x_wrap ? '0 : cand_x + 8'd1;
  assign step_y    = !x_wrap ? cand_y :
                     (cand_y == Y_LIM) ? '0 : cand_y + 8'd1;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = (state != S_IDLE);
    spawn_done  = 1'b0;
    spawn_fail  = 1'b0;
    occ.occ_req = 1'b0;
    occ.occ_x   = cand_x;
    occ.occ_y   = cand_y;
    unique case (state)
      S_IDLE: if (spawn_req) state_nxt = S_SET_X;
      S_SET_X: state_nxt = S_SAMP_X;
      S_SAMP_X: if (x_ok) state_nxt = S_SET_Y;
      S_SET_Y: state_nxt = S_SAMP_Y;
      S_SAMP_Y: if (y_ok) state_nxt = S_QUERY;
      S_QUERY: begin
        occ.occ_req = 1'b1;
        if (occ.occ_ack) begin
          if (!occ.occ_hit) state_nxt = S_DONE;
`ifdef FOOD_SCAN_EN
          else if (exhausted) state_nxt = S_SCAN;
`else
          else if (exhausted) state_nxt = S_FAIL;
`endif
          else state_nxt = S_SET_X;
        end
      end
`ifdef FOOD_SCAN_EN
      S_SCAN: begin
        occ.occ_req = 1'b1;
        if (occ.occ_ack) begin
          if (!occ.occ_hit)   state_nxt = S_DONE;
          else if (scan_last) state_nxt = S_FAIL;
        end
      end
`endif
      S_DONE: begin
        spawn_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      S_FAIL: begin
        spawn_fail = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rand_max   <= X_LIM;
      cand_x     <= '0;
      cand_y     <= '0;
      tries      <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
`ifdef FOOD_SCAN_EN
      scan_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (spawn_req) begin
            food_valid <= 1'b0;
            tries      <= '0;
          end
        end
        S_SET_X: rand_max <= X_LIM;
        S_SAMP_X: if (x_ok) cand_x <= rand_num;
        S_SET_Y: rand_max <= Y_LIM;
        S_SAMP_Y: if (y_ok) cand_y <= rand_num;
        S_QUERY: begin
          if (occ.occ_ack && occ.occ_hit) begin
            tries <= tries_inc;
`ifdef FOOD_SCAN_EN
            // scan starts from the cell after the last random pick
            if (exhausted) begin
              cand_x   <= step_x;
              cand_y   <= step_y;
              scan_cnt <= '0;
            end
`endif
          end
        end
`ifdef FOOD_SCAN_EN
        S_SCAN: begin
          if (occ.occ_ack && occ.occ_hit) begin
            cand_x   <= step_x;
            cand_y   <= step_y;
            scan_cnt <= scan_cnt + 16'd1;
          end
        end
`endif
        S_DONE: begin
          food_x     <= cand_x;
          food_y     <= cand_y;
          food_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_food_spawner.sv
// Randomized lock-step bench for food_spawner against a procedural model.
// Covers both builds; the scan fallback is modelled when FOOD_SCAN_EN is set.
module tb_food_spawner;
  import snake_pkg::*;

  localparam int W  = 40;
  localparam int H  = 30;
  localparam int MT = 4;

  logic   clock = 1'b0;
  logic   resetn = 1'b0;
  logic   spawn_req = 1'b0;
  coord_t rand_num = '0;
  coord_t rand_max;
  coord_t food_x;
  coord_t food_y;
  logic   food_valid;
  logic   spawn_done;
  logic   spawn_fail;
  logic   busy;

  food_spawner_if occ_bus ();

  food_spawner #(
    .GRID_W    (W),
    .GRID_H    (H),
    .MAX_TRIES (MT)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .spawn_req  (spawn_req),
    .rand_num   (rand_num),
    .rand_max   (rand_max),
    .occ        (occ_bus.master),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .spawn_done (spawn_done),
    .spawn_fail (spawn_fail),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int rq[$];
  int occ_mode;
  int hit_n;
  int free_x;
  int free_y;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic junk();
    rand_num = coord_t'($urandom_range(0, 255));
  endtask

  // Requests while busy must be ignored, so toggle them freely.
  task automatic adv_busy();
    spawn_req = 1'($urandom_range(0, 1));
    adv();
  endtask

  function automatic int next_rand();
    if (rq.size() > 0) return rq.pop_front();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 255));
    return int'($urandom_range(0, H - 1));
  endfunction

  function automatic bit occupied(int qn, int x, int y);
    case (occ_mode)
      0:       return 1'b0;
      1:       return qn < hit_n;
      2:       return 1'b1;
      default: return !(x == free_x && y == free_y);
    endcase
  endfunction

  task automatic expect_done(input int x, input int y);
    chk("done_pulse", 32'(spawn_done), 1);
    chk("done_nofail", 32'(spawn_fail), 0);
    chk("done_busy", 32'(busy), 1);
    chk("done_noreq", 32'(occ_bus.occ_req), 0);
    chk("done_valid0", 32'(food_valid), 0);
    junk();
    adv_busy();
    spawn_req = 1'b0;
    chk("after_done", 32'(spawn_done), 0);
    chk("after_busy", 32'(busy), 0);
    chk("food_valid", 32'(food_valid), 1);
    chk("food_x", 32'(food_x), x);
    chk("food_y", 32'(food_y), y);
    chk("max_kept", 32'(rand_max), H - 1);
  endtask

  task automatic expect_fail();
    chk("fail_pulse", 32'(spawn_fail), 1);
    chk("fail_nodone", 32'(spawn_done), 0);
    chk("fail_busy", 32'(busy), 1);
    chk("fail_noreq", 32'(occ_bus.occ_req), 0);
    junk();
    adv_busy();
    spawn_req = 1'b0;
    chk("after_fail", 32'(spawn_fail), 0);
    chk("after_fbusy", 32'(busy), 0);
    chk("fail_valid", 32'(food_valid), 0);
  endtask

  task automatic query(input int x, input int y, input int qn,
                       input bit fast, input bit abort,
                       output bit hit, output bit aborted);
    int d;
    d = fast ? 0 : int'($urandom_range(0, 2));
    hit = 1'b0;
    aborted = 1'b0;
    repeat (d) begin
      chk("q_wait_req", 32'(occ_bus.occ_req), 1);
      chk("q_wait_x", 32'(occ_bus.occ_x), x);
      chk("q_wait_y", 32'(occ_bus.occ_y), y);
      occ_bus.occ_ack = 1'b0;
      occ_bus.occ_hit = 1'($urandom_range(0, 1));
      junk();
      adv_busy();
    end
    chk("q_req", 32'(occ_bus.occ_req), 1);
    chk("q_x", 32'(occ_bus.occ_x), x);
    chk("q_y", 32'(occ_bus.occ_y), y);
    chk("q_busy", 32'(busy), 1);
    if (abort) begin
      resetn = 1'b0;
      spawn_req = 1'b0;
      occ_bus.occ_ack = 1'b0;
      adv();
      chk("rst_req", 32'(occ_bus.occ_req), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(spawn_done), 0);
      chk("rst_fail", 32'(spawn_fail), 0);
      chk("rst_valid", 32'(food_valid), 0);
      chk("rst_fx", 32'(food_x), 0);
      chk("rst_fy", 32'(food_y), 0);
      chk("rst_max", 32'(rand_max), W - 1);
      resetn = 1'b1;
      adv();
      adv();
      chk("rst_idle", 32'(busy), 0);
      aborted = 1'b1;
      return;
    end
    hit = occupied(qn, x, y);
    occ_bus.occ_ack = 1'b1;
    occ_bus.occ_hit = hit;
    junk();
    adv_busy();
    occ_bus.occ_ack = 1'b0;
    occ_bus.occ_hit = 1'($urandom_range(0, 1));
  endtask

`ifdef FOOD_SCAN_EN
  // Cells are visited in row-major order starting after the last pick.
  task automatic scan_run(input int x0, input int y0, input int qn0);
    int  idx;
    int  qn;
    bit  hit;
    bit  ab;
    idx = y0 * W + x0;
    qn = qn0;
    for (int k = 0; k < W * H; k++) begin
      idx = (idx + 1) % (W * H);
      query(idx % W, idx / W, qn, $urandom_range(0, 3) != 0,
            1'b0, hit, ab);
      qn++;
      if (!hit) begin
        expect_done(idx % W, idx / W);
        return;
      end
    end
    expect_fail();
  endtask
`endif

  task automatic spawn_run(input int mode, input int hitn,
                           input bit fast, input bit abort);
    int x;
    int y;
    int v;
    int tries;
    int qn;
    bit hit;
    bit ab;
    bit fin;
    occ_mode = mode;
    hit_n = hitn;
    chk("idle_busy", 32'(busy), 0);
    spawn_req = 1'b1;
    junk();
    adv();
    tries = 0;
    qn = 0;
    fin = 1'b0;
    while (!fin) begin
      chk("setx_busy", 32'(busy), 1);
      chk("setx_noreq", 32'(occ_bus.occ_req), 0);
      junk();
      adv_busy();
      do begin
        chk("x_max", 32'(rand_max), W - 1);
        chk("x_noreq", 32'(occ_bus.occ_req), 0);
        v = next_rand();
        rand_num = coord_t'(v);
        adv_busy();
      end while (v > W - 1);
      x = v;
      chk("sety_busy", 32'(busy), 1);
      junk();
      adv_busy();
      do begin
        chk("y_max", 32'(rand_max), H - 1);
        v = next_rand();
        rand_num = coord_t'(v);
        adv_busy();
      end while (v > H - 1);
      y = v;
      query(x, y, qn, fast, abort, hit, ab);
      qn++;
      if (ab) return;
      if (!hit) begin
        expect_done(x, y);
        fin = 1'b1;
      end else begin
        tries++;
        if (tries == MT) begin
`ifdef FOOD_SCAN_EN
          scan_run(x, y, qn);
`else
          expect_fail();
`endif
          fin = 1'b1;
        end
      end
    end
  endtask

  task automatic idle_gap();
    spawn_req = 1'b0;
    adv();
    chk("gap_busy", 32'(busy), 0);
    chk("gap_done", 32'(spawn_done), 0);
  endtask

  initial begin
    occ_bus.occ_ack = 1'b0;
    occ_bus.occ_hit = 1'b0;
    @(negedge clock);
    adv();
    adv();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_max", 32'(rand_max), W - 1);
    chk("reset_req", 32'(occ_bus.occ_req), 0);
    chk("reset_valid", 32'(food_valid), 0);
    chk("reset_fx", 32'(food_x), 0);
    chk("reset_fy", 32'(food_y), 0);
    chk("reset_done", 32'(spawn_done), 0);
    chk("reset_fail", 32'(spawn_fail), 0);
    resetn = 1'b1;
    adv();

    rq = '{7, 12};
    spawn_run(0, 0, 1'b1, 1'b0);
    idle_gap();

    rq = '{45, 45, 45, 20};
    spawn_run(0, 0, 1'b0, 1'b0);
    idle_gap();

    spawn_run(1, 2, 1'b0, 1'b0);
    idle_gap();

    spawn_run(2, 0, 1'b0, 1'b0);
    idle_gap();

    free_x = int'($urandom_range(0, W - 1));
    free_y = int'($urandom_range(0, H - 1));
    spawn_run(3, 0, 1'b0, 1'b0);
    idle_gap();

    spawn_run(0, 0, 1'b0, 1'b1);
    spawn_run(0, 0, 1'b0, 1'b0);
    idle_gap();

    for (int i = 0; i < 16; i++) begin
      int m;
      m = int'($urandom_range(0, 2));
      if (m == 2) m = 3;
      free_x = int'($urandom_range(0, W - 1));
      free_y = int'($urandom_range(0, H - 1));
      spawn_run(m, int'($urandom_range(0, 5)),
                $urandom_range(0, 1) == 1, 1'b0);
      idle_gap();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
